fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares the single write port of the team's asynchronous FIFO (wdv/wdata/wfull) between NREQ requesters in the wclk domain.
- Once a requester is granted, it owns the port until its last beat is accepted, so packets are never interleaved in the FIFO.
- Sits directly in front of the FIFO write side; the FIFO's wfull is the only backpressure source.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWIDTH, 32, data width; must match the FIFO DWIDTH.
- IDW, 2, width of grant_id; equals clog2(NREQ).

Ports:
- wclk  in  1  write-domain clock.
- arst  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  per-requester beat valid.
- req_data  in  NREQ*DWIDTH  flattened beats; requester i occupies bits [i*DWIDTH +: DWIDTH].
- req_last  in  NREQ  per-requester last-beat-of-packet flag.
- req_ready  out  NREQ  per-requester beat accepted this cycle when valid&ready.
- fifo_wdv  out  1  write strobe to FIFO wdv.
- fifo_wdata  out  DWIDTH  write data to FIFO wdata.
- fifo_wfull  in  1  FIFO wfull.
- grant_id  out  IDW  index of current owner; valid while busy.
- busy  out  1  a packet is in progress (state LOCK).

Behaviour:
- Reset (arst=1, async): state=IDLE, rr_ptr=0, grant_id=0, busy=0. req_ready=0, fifo_wdv=0, fifo_wdata=0 while in reset.
- States:
  - IDLE: if any req_valid, pick the first set bit searching rr_ptr, rr_ptr+1, ... mod NREQ. Register it into grant_id, set busy=1, go to LOCK. One-cycle arbitration bubble; no beat is accepted in IDLE.
  - LOCK:
    - req_ready[grant_id] = ~fifo_wfull; all other req_ready bits = 0.
    - fifo_wdv = req_valid[grant_id] & ~fifo_wfull. Combinational, zero latency.
    - fifo_wdata = req_data slice of grant_id when fifo_wdv=1, else 0.
  - LOCK exit: a beat accepted with req_last[grant_id]=1 → next state IDLE, busy=0, rr_ptr = grant_id+1 mod NREQ.
- Handshake rules:
  - A beat transfers iff req_valid & req_ready in the same wclk edge.
  - Requesters must hold data and last stable while valid and not ready.
  - Dropping valid mid-packet is legal; the owner keeps the grant and the arbiter waits indefinitely.
- Full: while fifo_wfull=1, fifo_wdv=0 and req_ready=0. A write is never issued into a full FIFO. The grant is held across the full period.
- Fairness:
  - Owner index i has the lowest priority at the next arbitration.
  - With all NREQ requesters continuously valid, grants rotate 0,1,..,NREQ-1,0.
  - Worst-case wait is NREQ-1 packets.
- Single-beat packet (valid & last on the first beat): LOCK for one cycle, then IDLE. Minimum packet period is 2 cycles.
- Requests in IDLE that arrive together are resolved purely by rr_ptr order. Requesters that are not granted see no side effect.
- Reset mid-packet: the packet is truncated and arbitration restarts from rr_ptr=0. The downstream consumer handles partial packets.

Optional Feature:
- Macro ARB_PKT_CNT_EN.
- Defined:
  - Adds output pkt_cnt (NREQ*16 bits, flattened). Field i counts packets completed by requester i, incremented on the accepted last beat.
  - Counters wrap modulo 2^16 and reset to 0 on arst.
- Undefined: port and counters are absent, and the behaviour above is otherwise identical.

Decomposition:
- Shared package holds:
  - state encoding localparams IDLE=1'b0, LOCK=1'b1;
  - a clog2 function for IDW derivation.
- One natural sub-module, rr_pick: purely combinational. It takes req_valid and rr_ptr and returns the winner index plus a found flag. It is reusable by other arbiters in the design.

Test Plan:
- Single requester: NREQ=4, req1 sends 3 beats 0xA0,0xA1,0xA2 (last on 0xA2) with fifo_wfull=0 → grant_id=1 and busy from cycle 1; fifo_wdv high cycles 1-3 carrying 0xA0..0xA2; busy=0 at cycle 4.
- Round-robin: all four requesters valid continuously with 1-beat packets → grant order 0,1,2,3,0 with one fifo_wdv every 2 cycles; req_ready never high for a non-owner.
- Backpressure: req2 is mid-packet and fifo_wfull is asserted for 5 cycles → fifo_wdv=0 and req_ready=0 for those 5 cycles; the grant stays 2; the packet resumes with no lost or duplicated beat.
- Owner bubble: req0 drops valid for 3 cycles mid-packet while req3 is valid → req3 is not granted until req0's last beat is accepted; req3 is granted next.
- Reset mid-packet: arst pulsed during req1's second beat → all outputs 0 immediately; after release, req2 and req3 both valid → req2 wins (rr_ptr=0 search order).
- ARB_PKT_CNT_EN: 70000 single-beat packets from req0 → pkt_cnt field 0 = 70000 mod 65536 = 4464; other fields 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
// Holds the FSM state encoding and the clog2 helper used to size grant_id.
// Optional build macro used by the top: ARB_PKT_CNT_EN.
package fifo_wr_arbiter_pkg;

  // FSM encoding kept as plain constants so older flows can read them.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  // Width of each per-requester completed-packet counter.
  localparam int PKT_CNT_W = 16;

  // Ceiling log2; returns the number of bits needed to index 'value' items.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches req_valid starting at rr_ptr and wrapping modulo NREQ; the first
// set bit wins. Reusable by any arbiter that keeps its own pointer.
module fifo_wr_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [IDW-1:0]  winner,
  output logic            found
);

  // Index examined at search offset gi, and whether that requester is valid.
  logic [IDW-1:0]  w_idx [NREQ];
  logic [NREQ-1:0] w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_off
      logic [IDW:0] w_sum;
      // One extra bit so rr_ptr+gi never overflows before the wrap.
      assign w_sum       = {1'b0, rr_ptr} + (IDW+1)'(gi);
      assign w_idx[gi]   = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ))
                                                     : w_sum[IDW-1:0];
      assign w_hit[gi]   = req_valid[w_idx[gi]];
    end
  endgenerate

  // Priority over offsets: scanning downward lets the smallest offset win.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        winner = w_idx[k];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter in front of the async FIFO write port.
// A granted requester owns the port until its last beat is accepted, so
// packets never interleave. fifo_wfull is the only backpressure source.
// Build macro ARB_PKT_CNT_EN adds per-requester completed-packet counters
// on output pkt_cnt (NREQ x 16 bits, flattened).
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 32,
  parameter int IDW    = clog2(NREQ)
) (
  input  logic                   wclk,
  input  logic                   arst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic                   fifo_wdv,
  output logic [DWIDTH-1:0]      fifo_wdata,
  input  logic                   fifo_wfull,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy
`ifdef ARB_PKT_CNT_EN
  ,
  output logic [NREQ*PKT_CNT_W-1:0] pkt_cnt
`endif
);

  logic [0:0]      r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_grant_id;

  logic            w_lock;
  logic [IDW-1:0]  w_winner;
  logic            w_found;
  logic            w_owner_valid;
  logic            w_owner_last;
  logic [DWIDTH-1:0] w_owner_data;
  logic [DWIDTH-1:0] w_data_arr [NREQ];
  logic            w_accept;
  logic            w_pkt_done;
  logic [IDW-1:0]  w_ptr_after;

  fifo_wr_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (r_rr_ptr),
    .winner    (w_winner),
    .found     (w_found)
  );

  assign w_lock = (r_state == LOCK);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_data_arr[gi] = req_data[gi*DWIDTH +: DWIDTH];
      // Only the owner sees ready, and only while the FIFO has room.
      assign req_ready[gi]  = w_lock & ~fifo_wfull & (r_grant_id == IDW'(gi));
    end
  endgenerate

  assign w_owner_valid = req_valid[r_grant_id];
  assign w_owner_last  = req_last[r_grant_id];
  assign w_owner_data  = w_data_arr[r_grant_id];

  // A beat moves when the owner is valid and the FIFO is not full.
  assign w_accept   = w_lock & w_owner_valid & ~fifo_wfull;
  assign w_pkt_done = w_accept & w_owner_last;

  assign fifo_wdv   = w_accept;
  assign fifo_wdata = w_accept ? w_owner_data : '0;
  assign grant_id   = r_grant_id;
  assign busy       = w_lock;

  // The finished owner drops to lowest priority for the next search.
  assign w_ptr_after = (r_grant_id == IDW'(NREQ - 1)) ? '0 : r_grant_id + IDW'(1);

  // Arbitration FSM: IDLE picks an owner, LOCK holds it until the last beat.
  always_ff @(posedge wclk or posedge arst) begin
    if (arst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_id <= w_winner;
            r_state    <= LOCK;
          end
        end
        LOCK: begin
          if (w_pkt_done) begin
            r_rr_ptr <= w_ptr_after;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PKT_CNT_EN
  logic [PKT_CNT_W-1:0] r_pkt_cnt [NREQ];

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cnt
      // Count completed packets per requester; wraps naturally at 2^16.
      always_ff @(posedge wclk or posedge arst) begin
        if (arst) begin
          r_pkt_cnt[gi] <= '0;
        end else if (w_pkt_done && (r_grant_id == IDW'(gi))) begin
          r_pkt_cnt[gi] <= r_pkt_cnt[gi] + PKT_CNT_W'(1);
        end
      end
      assign pkt_cnt[gi*PKT_CNT_W +: PKT_CNT_W] = r_pkt_cnt[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DWIDTH=32).
// Each vector drives one cycle of inputs and checks the combinational
// outputs mid-cycle against hand-computed values.
module tb_fifo_wr_arbiter;

  localparam int NREQ   = 4;
  localparam int DWIDTH = 32;
  localparam int IDW    = 2;

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;    // byte i is requester i's beat, zero-extended
    logic        wf;
    logic [3:0]  e_rdy;
    logic        e_wdv;
    logic [31:0] e_wd;
    logic [1:0]  e_gid;
    logic        e_bsy;
  } vec_t;

  logic                   wclk;
  logic                   arst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic                   fifo_wdv;
  logic [DWIDTH-1:0]      fifo_wdata;
  logic                   fifo_wfull;
  logic [IDW-1:0]         grant_id;
  logic                   busy;
`ifdef ARB_PKT_CNT_EN
  logic [NREQ*16-1:0]     pkt_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int vec_no = 0;
  vec_t tbl[$];

  fifo_wr_arbiter #(
    .NREQ   (NREQ),
    .DWIDTH (DWIDTH),
    .IDW    (IDW)
  ) dut (
    .wclk       (wclk),
    .arst       (arst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wdv   (fifo_wdv),
    .fifo_wdata (fifo_wdata),
    .fifo_wfull (fifo_wfull),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef ARB_PKT_CNT_EN
    ,
    .pkt_cnt    (pkt_cnt)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] l,
                              input logic [31:0] d, input logic wf, input logic [3:0] e_rdy,
                              input logic e_wdv, input logic [31:0] e_wd,
                              input logic [1:0] e_gid, input logic e_bsy);
    vec_t r;
    r.rst = rst; r.v = v; r.l = l; r.d = d; r.wf = wf;
    r.e_rdy = e_rdy; r.e_wdv = e_wdv; r.e_wd = e_wd; r.e_gid = e_gid; r.e_bsy = e_bsy;
    return r;
  endfunction

  // Drive one cycle of stimulus just after the edge, check at the falling edge.
  task automatic run_vec(input vec_t r);
    logic gid_bad;
    @(posedge wclk);
    #1;
    arst       = r.rst;
    req_valid  = r.v;
    req_last   = r.l;
    fifo_wfull = r.wf;
    for (int i = 0; i < NREQ; i++)
      req_data[i*DWIDTH +: DWIDTH] = {24'h0, r.d[i*8 +: 8]};
    @(negedge wclk);
    // grant_id is only meaningful while busy, or as the reset value.
    gid_bad = (r.e_bsy || r.rst) && (grant_id !== r.e_gid);
    checks++;
    if (req_ready !== r.e_rdy || fifo_wdv !== r.e_wdv || fifo_wdata !== r.e_wd ||
        busy !== r.e_bsy || gid_bad) begin
      errors++;
      $display("FAIL vec%0d: got rdy=%b wdv=%b wd=%h gid=%0d busy=%b, want rdy=%b wdv=%b wd=%h gid=%0d busy=%b",
               vec_no, req_ready, fifo_wdv, fifo_wdata, grant_id, busy,
               r.e_rdy, r.e_wdv, r.e_wd, r.e_gid, r.e_bsy);
    end else begin
      $display("vec%0d ok: rdy=%b wdv=%b wd=%h gid=%0d busy=%b",
               vec_no, req_ready, fifo_wdv, fifo_wdata, grant_id, busy);
    end
    vec_no++;
  endtask

  initial begin
    arst       = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    fifo_wfull = 1'b0;

    // Reset state, then single requester, then continuous round-robin.
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 0, 32'h0, 2'd0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000A000, 0, 4'b0000, 0, 32'h0, 2'd0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000A000, 0, 4'b0010, 1, 32'hA0, 2'd1, 1));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000A100, 0, 4'b0010, 1, 32'hA1, 2'd1, 1));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 32'h0000A200, 0, 4'b0010, 1, 32'hA2, 2'd1, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 0, 32'h0, 2'd0, 0));
    // rr_ptr is now 2: expected owners 2,3,0,1,2 with an idle bubble between.
    for (int k = 0; k < 5; k++) begin
      logic [1:0] g;
      g = 2'(k + 2);
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 0, 4'b0000, 0, 32'h0, 2'd0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 0, 4'(1 << g), 1,
                       32'h10 + 32'(g), g, 1));
    end
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 0, 32'h0, 2'd0, 0));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Backpressure: req2 owns the port, FIFO full for 5 cycles mid-packet.
    run_vec(mk(0, 4'b0100, 4'b0000, 32'h00B0C1C0, 0, 4'b0000, 0, 32'h0, 2'd0, 0));
    run_vec(mk(0, 4'b0111, 4'b0000, 32'h00B0C1C0, 0, 4'b0100, 1, 32'hB0, 2'd2, 1));
    for (int k = 0; k < 5; k++)
      run_vec(mk(0, 4'b0111, 4'b0000, 32'h00B1C1C0, 1, 4'b0000, 0, 32'h0, 2'd2, 1));
    run_vec(mk(0, 4'b0111, 4'b0000, 32'h00B1C1C0, 0, 4'b0100, 1, 32'hB1, 2'd2, 1));
    run_vec(mk(0, 4'b0111, 4'b0100, 32'h00B2C1C0, 0, 4'b0100, 1, 32'hB2, 2'd2, 1));

    // Owner bubble: req0 drops valid for 3 cycles while req3 waits.
    run_vec(mk(0, 4'b0001, 4'b0000, 32'hE00000D0, 0, 4'b0000, 0, 32'h0, 2'd0, 0));
    run_vec(mk(0, 4'b1001, 4'b0000, 32'hE00000D0, 0, 4'b0001, 1, 32'hD0, 2'd0, 1));
    for (int k = 0; k < 3; k++)
      run_vec(mk(0, 4'b1000, 4'b1000, 32'hE00000D1, 0, 4'b0001, 0, 32'h0, 2'd0, 1));
    run_vec(mk(0, 4'b1001, 4'b1001, 32'hE00000D1, 0, 4'b0001, 1, 32'hD1, 2'd0, 1));
    run_vec(mk(0, 4'b1000, 4'b1000, 32'hE00000D1, 0, 4'b0000, 0, 32'h0, 2'd0, 0));
    run_vec(mk(0, 4'b1000, 4'b1000, 32'hE00000D1, 0, 4'b1000, 1, 32'hE0, 2'd3, 1));
    run_vec(mk(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 0, 32'h0, 2'd0, 0));

    // Reset during req1's second beat, then req2/req3 resolve from rr_ptr=0.
    run_vec(mk(0, 4'b0010, 4'b0000, 32'h0000F000, 0, 4'b0000, 0, 32'h0, 2'd0, 0));
    run_vec(mk(0, 4'b0010, 4'b0000, 32'h0000F000, 0, 4'b0010, 1, 32'hF0, 2'd1, 1));
    run_vec(mk(1, 4'b0010, 4'b0000, 32'h0000F100, 0, 4'b0000, 0, 32'h0, 2'd0, 0));
    run_vec(mk(0, 4'b1100, 4'b1100, 32'h33220000, 0, 4'b0000, 0, 32'h0, 2'd0, 0));
    run_vec(mk(0, 4'b1100, 4'b1100, 32'h33220000, 0, 4'b0100, 1, 32'h22, 2'd2, 1));
    run_vec(mk(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 0, 32'h0, 2'd0, 0));

    // Back-to-back single-beat packets from req0 only: 2-cycle period.
    for (int k = 0; k < 20; k++) begin
      run_vec(mk(0, 4'b0001, 4'b0001, 32'h0000005A, 0, 4'b0000, 0, 32'h0, 2'd0, 0));
      run_vec(mk(0, 4'b0001, 4'b0001, 32'h0000005A, 0, 4'b0001, 1, 32'h5A, 2'd0, 1));
    end
    run_vec(mk(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 0, 32'h0, 2'd0, 0));

`ifdef ARB_PKT_CNT_EN
    // Since the reset: one packet from req2, twenty from req0.
    for (int i = 0; i < NREQ; i++) begin
      logic [15:0] exp_cnt;
      exp_cnt = (i == 0) ? 16'd20 : (i == 2) ? 16'd1 : 16'd0;
      checks++;
      if (pkt_cnt[i*16 +: 16] !== exp_cnt) begin
        errors++;
        $display("FAIL pkt_cnt[%0d]: got %0d, want %0d", i, pkt_cnt[i*16 +: 16], exp_cnt);
      end else begin
        $display("pkt_cnt[%0d] ok: %0d", i, pkt_cnt[i*16 +: 16]);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
